// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes a 4x4 keypad's rows active-low, samples its columns, debounces and emits one code per press.
// Latency: key_valid rises 1 cycle after the row-3 sample edge of the DEBOUNCE_SCANS-th qualifying frame.
// Backpressure: none; key_valid is a one-cycle pulse and key_code holds until the next accepted press.

module keypad_scanner #(
    parameter int ROW_DWELL      = 10,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_10000Hz,
    input  logic       reset,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int DW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    // Column synchronizer
    logic [3:0] col_s1_q;
    logic [3:0] col_s2_q;

    // Scan counter and frame record
    logic [DW-1:0]   dwell_q;
    logic [DW-1:0]   dwell_d;
    logic [1:0]      row_idx_q;
    logic [1:0]      row_idx_d;
    logic [3:0]      key_row_q;
    logic [3:0]      key_row_d;
    logic [3:0][3:0] frame_q;
    logic [3:0][3:0] frame_d;
    logic            eval_q;
    logic            eval_d;
    logic            sample;

    // Frame classification
    logic [4:0] n_low;
    logic [3:0] single_code;
    logic       cls_none;
    logic       cls_single;

    // Debounce FSM and registered outputs
    state_t        state_q;
    state_t        state_d;
    logic [3:0]    cand_q;
    logic [3:0]    cand_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;
    logic          release_key;
    logic [3:0]    key_code_q;
    logic [3:0]    key_code_d;
    logic          key_valid_q;
    logic          key_valid_d;
    logic          key_pressed_q;
    logic          key_pressed_d;

    // Two-flop synchronizer for the asynchronous column lines (idle high = no key)
    always_ff @(posedge clk_10000Hz or negedge reset) begin
        if (!reset) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
        end else begin
            col_s1_q <= key_col;
            col_s2_q <= col_s1_q;
        end
    end

    // Next-state for the row scan: sample at the last dwell cycle, then step to the next row
    always_comb begin
        sample    = (dwell_q == DWELL_LAST);
        dwell_d   = sample ? '0 : dwell_q + DW'(1);
        row_idx_d = sample ? row_idx_q + 2'd1 : row_idx_q;
        key_row_d = ~(4'b0001 << row_idx_d);
        frame_d   = frame_q;
        if (sample) begin
            frame_d[row_idx_q] = col_s2_q;
        end
        // A completed frame is flagged on the row-3 sample edge; the FSM consumes it on the next edge
        eval_d    = sample && (row_idx_q == 2'd3);
    end

    // Scan registers; key_row is registered so the strobe never glitches
    always_ff @(posedge clk_10000Hz or negedge reset) begin
        if (!reset) begin
            dwell_q   <= '0;
            row_idx_q <= 2'd0;
            key_row_q <= 4'b1110;
            frame_q   <= '1;
            eval_q    <= 1'b0;
        end else begin
            dwell_q   <= dwell_d;
            row_idx_q <= row_idx_d;
            key_row_q <= key_row_d;
            frame_q   <= frame_d;
            eval_q    <= eval_d;
        end
    end

    // Classify the stored frame: count low column bits and remember where the (only) one is
    always_comb begin
        n_low       = 5'd0;
        single_code = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!frame_q[r][c]) begin
                    n_low       = n_low + 5'd1;
                    single_code = 4'(r * 4 + c);
                end
            end
        end
        cls_none   = (n_low == 5'd0);
        cls_single = (n_low == 5'd1);
    end

    // FSM state register together with the registered outputs
    always_ff @(posedge clk_10000Hz or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cand_q        <= 4'd0;
            cnt_q         <= '0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    // FSM next state: evaluated only once per frame, otherwise holds
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        release_key = 1'b0;
        if (eval_q) begin
            case (state_q)
                IDLE: begin
                    if (cls_single) begin
                        cand_d = single_code;
                        if (CNT_ONE == CNT_MAX) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            accept  = 1'b1;
                        end else begin
                            state_d = PRESS_DB;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                PRESS_DB: begin
                    if (cls_single) begin
                        if (single_code == cand_q) begin
                            if (cnt_q + CNT_ONE == CNT_MAX) begin
                                state_d = HELD;
                                cnt_d   = '0;
                                accept  = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end else begin
                            // Different key: restart the count on the new candidate
                            cand_d = single_code;
                            cnt_d  = CNT_ONE;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    // Only an empty frame starts release; other keys are ignored (no rollover)
                    if (cls_none) begin
                        if (CNT_ONE == CNT_MAX) begin
                            state_d     = IDLE;
                            cnt_d       = '0;
                            release_key = 1'b1;
                        end else begin
                            state_d = REL_DB;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                REL_DB: begin
                    if (cls_none) begin
                        if (cnt_q + CNT_ONE == CNT_MAX) begin
                            state_d     = IDLE;
                            cnt_d       = '0;
                            release_key = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM outputs: latch the code and pulse valid on accept, track the held level
    always_comb begin
        key_code_d    = accept ? cand_d : key_code_q;
        key_valid_d   = accept;
        key_pressed_d = key_pressed_q;
        if (accept) begin
            key_pressed_d = 1'b1;
        end else if (release_key) begin
            key_pressed_d = 1'b0;
        end
    end

    assign key_row     = key_row_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;

endmodule
